// File: rtl/mult_parity_pipe.sv
// Pipelined multiplier with even-parity checking on both operands, credit-based req/ack
// admission, a first-word fall-through result queue and a saturating parity-error counter.
module mult_parity_pipe #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     arg_a,
  input  logic                  arg_a_parity,
  input  logic [DATA_W-1:0]     arg_b,
  input  logic                  arg_b_parity,
  input  logic                  mode_signed,
  input  logic                  req,
  output logic                  ack,
  output logic [2*DATA_W-1:0]   result,
  output logic                  result_parity,
  output logic                  result_rdy,
  input  logic                  result_taken,
  output logic                  arg_parity_error,
  output logic [15:0]           err_count
);

  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned ENT_W = RES_W + 2;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0]         outstanding;
  logic signed [DATA_W:0]   a_ext;
  logic signed [DATA_W:0]   b_ext;
  logic [RES_W-1:0]         prod;
  logic                     in_err;
  logic [ENT_W-1:0]         in_ent;

  logic [LATENCY-1:0]       p_vld;
  logic [ENT_W-1:0]         p_ent [LATENCY];

  logic [FIFO_DEPTH-1:0]    q_vld;
  logic [ENT_W-1:0]         q_ent [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    q_vld_nxt;
  logic [ENT_W-1:0]         q_ent_nxt [FIFO_DEPTH];
  logic [CNT_W-1:0]         q_cnt;
  logic [CNT_W-1:0]         wr_pos;
  logic                     pop_c;
  logic                     wr_c;

  // Credit covers both pipeline and queue, so the queue can never overflow.
  assign ack = req && !reset && (outstanding < CNT_W'(FIFO_DEPTH));

  // One extra bit per operand lets a single signed multiply serve both modes.
  assign a_ext  = {mode_signed & arg_a[DATA_W-1], arg_a};
  assign b_ext  = {mode_signed & arg_b[DATA_W-1], arg_b};
  assign prod   = RES_W'(a_ext) * RES_W'(b_ext);
  assign in_err = (arg_a_parity != ^arg_a) || (arg_b_parity != ^arg_b);
  assign in_ent = in_err ? {1'b1, {(RES_W + 1){1'b0}}} : {1'b0, ^prod, prod};

  // Result pipeline
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_vld <= '0;
      for (int i = 0; i < LATENCY; i++) p_ent[i] <= '0;
    end else begin
      p_vld[0] <= ack;
      p_ent[0] <= in_ent;
      for (int i = 1; i < LATENCY; i++) begin
        p_vld[i] <= p_vld[i-1];
        p_ent[i] <= p_ent[i-1];
      end
    end
  end

  assign pop_c = q_vld[0] && result_taken;
  assign wr_c  = p_vld[LATENCY-1];

  always_comb begin
    q_cnt = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) q_cnt = q_cnt + CNT_W'(q_vld[i]);
  end

  assign wr_pos = pop_c ? q_cnt - CNT_W'(1) : q_cnt;

  // Shift-register queue: entry 0 is the head; vacated slots are zeroed so an empty head reads 0.
  always_comb begin
    q_vld_nxt = q_vld;
    q_ent_nxt = q_ent;
    if (pop_c) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        q_vld_nxt[i] = q_vld[i+1];
        q_ent_nxt[i] = q_ent[i+1];
      end
      q_vld_nxt[FIFO_DEPTH-1] = 1'b0;
      q_ent_nxt[FIFO_DEPTH-1] = '0;
    end
    if (wr_c) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (CNT_W'(i) == wr_pos) begin
          q_vld_nxt[i] = 1'b1;
          q_ent_nxt[i] = p_ent[LATENCY-1];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_vld       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) q_ent[i] <= '0;
      outstanding <= '0;
      err_count   <= '0;
    end else begin
      q_vld       <= q_vld_nxt;
      q_ent       <= q_ent_nxt;
      outstanding <= outstanding + CNT_W'(ack) - CNT_W'(pop_c);
      if (ack && in_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end

  assign result_rdy       = q_vld[0];
  assign result           = q_ent[0][RES_W-1:0];
  assign result_parity    = q_ent[0][RES_W];
  assign arg_parity_error = q_ent[0][RES_W+1];

endmodule
